// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: 16-bit fetch PC, small {pc, instr} prefetch FIFO and IF/ID output register.
// Define PREFETCH_BUF_EN for a 2-entry prefetch FIFO; by default the FIFO has one entry.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        halted
);

`ifdef PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [15:0] HALT_INSTR = 16'hBF00;
  localparam logic [1:0]  DEPTH_CNT  = 2'(DEPTH);
  localparam logic        PTR_STEP   = (DEPTH == 2);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    FETCH      = 2'd1,
    WAIT_SPACE = 2'd2,
    HALT       = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] fetch_pc;
  logic [15:0] fifo_pc    [2];
  logic [15:0] fifo_instr [2];
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        transfer;
  logic        pop;
  logic        unused_redirect_lsb;

  // Memory handshake: a transfer happens on any rising edge where imem_req and
  // imem_ack are both high; imem_addr holds while a request waits for its ack,
  // and a redirect may drop imem_req at any time to abandon a pending request.
  assign imem_req  = (state == FETCH) && !redirect;
  assign imem_addr = fetch_pc;
  assign halted    = (state == HALT);
  assign transfer  = imem_req && imem_ack;
  assign pop       = !redirect && !stall && (count != 2'd0);

  assign unused_redirect_lsb = redirect_pc[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FETCH;
    end else begin
      case (state)
        BOOT: state_next = FETCH;
        FETCH: begin
          if (transfer) begin
            if (imem_rdata == HALT_INSTR) begin
              state_next = HALT;
            end else if ((count + 2'd1 == DEPTH_CNT) && !pop) begin
              state_next = WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (count < DEPTH_CNT) begin
            state_next = FETCH;
          end
        end
        HALT: state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[15:1], 1'b0};
    end else if (transfer) begin
      fetch_pc <= fetch_pc + 16'd2;
    end
  end

  // With a single entry both pointers stay at slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_pc[0]    <= 16'h0000;
      fifo_pc[1]    <= 16'h0000;
      fifo_instr[0] <= 16'h0000;
      fifo_instr[1] <= 16'h0000;
    end else if (redirect) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (transfer) begin
        fifo_pc[wr_ptr]    <= fetch_pc;
        fifo_instr[wr_ptr] <= imem_rdata;
        wr_ptr             <= wr_ptr ^ PTR_STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr ^ PTR_STEP;
      end
      case ({transfer, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A bubble keeps if_pc so the decoder always sees the last real address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_instr <= HALT_INSTR;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
    end else if (redirect) begin
      if_instr <= HALT_INSTR;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if (count != 2'd0) begin
        if_instr <= fifo_instr[rd_ptr];
        if_pc    <= fifo_pc[rd_ptr];
        if_valid <= 1'b1;
      end else begin
        if_instr <= HALT_INSTR;
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory answers addr + 16'h1000, or 16'hBF00 at halt_addr.
module tb_instr_fetch_unit;

`ifdef PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        halt_en;
  logic [15:0] halt_addr;
  int          n_checks;
  int          n_errors;
  int          xfer_cnt;

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_instr(if_instr),
    .if_pc(if_pc), .if_valid(if_valid), .halted(halted)
  );

  // Clock and stateless memory responder
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = (halt_en && imem_addr == halt_addr) ? 16'hBF00 : imem_addr + 16'h1000;

  always @(posedge clk) begin
    if (imem_req && imem_ack) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_ack = 1'b1; halt_en = 1'b0; halt_addr = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_ack = 1'b1; halt_en = 1'b0; halt_addr = 16'h0000;
    tick();
    tick();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (if_instr !== 16'hBF00) begin n_errors++; $display("FAIL reset_instr: got %h want bf00", if_instr); end
    n_checks++; if (if_pc !== 16'h0000) begin n_errors++; $display("FAIL reset_pc: got %h want 0000", if_pc); end
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (imem_addr !== 16'h0000) begin n_errors++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc [7];
    logic        exp_v  [7];
    logic [15:0] exp_instr;
`ifdef PREFETCH_BUF_EN
    exp_pc = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A, 16'h000C};
    exp_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_pc = '{16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0002, 16'h0004};
    exp_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    do_reset();
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL seq_req_e1: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 16'h0000) begin n_errors++; $display("FAIL seq_addr_e1: got %h want 0000", imem_addr); end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL seq_valid_e2: got %b want 0", if_valid); end
    for (int e = 0; e < 7; e++) begin
      tick();
      exp_instr = exp_v[e] ? exp_pc[e] + 16'h1000 : 16'hBF00;
      n_checks++; if (if_valid !== exp_v[e]) begin n_errors++; $display("FAIL seq_valid_e%0d: got %b want %b", e + 3, if_valid, exp_v[e]); end
      n_checks++; if (if_pc !== exp_pc[e]) begin n_errors++; $display("FAIL seq_pc_e%0d: got %h want %h", e + 3, if_pc, exp_pc[e]); end
      n_checks++; if (if_instr !== exp_instr) begin n_errors++; $display("FAIL seq_instr_e%0d: got %h want %h", e + 3, if_instr, exp_instr); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    stall = 1'b1;
    tick();
    tick();
    tick();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL redir_full_req: got %b want 0", imem_req); end
    redirect = 1'b1; redirect_pc = 16'h0041;
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL redir_bubble_valid: got %b want 0", if_valid); end
    n_checks++; if (if_instr !== 16'hBF00) begin n_errors++; $display("FAIL redir_bubble_instr: got %h want bf00", if_instr); end
    n_checks++; if (if_pc !== 16'h0000) begin n_errors++; $display("FAIL redir_bubble_pc: got %h want 0000", if_pc); end
    redirect = 1'b0; stall = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL redir_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 16'h0040) begin n_errors++; $display("FAIL redir_addr: got %h want 0040", imem_addr); end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL redir_no_stale: got valid %b pc %h want 0", if_valid, if_pc); end
    tick();
    n_checks++; if (if_valid !== 1'b1) begin n_errors++; $display("FAIL redir_first_valid: got %b want 1", if_valid); end
    n_checks++; if (if_pc !== 16'h0040) begin n_errors++; $display("FAIL redir_first_pc: got %h want 0040", if_pc); end
    n_checks++; if (if_instr !== 16'h1040) begin n_errors++; $display("FAIL redir_first_instr: got %h want 1040", if_instr); end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0010; halt_en = 1'b1; halt_addr = 16'h0010;
    tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 16'h0010) begin n_errors++; $display("FAIL halt_addr: got %h want 0010", imem_addr); end
    tick();
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_flag: got %b want 1", halted); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL halt_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (if_valid !== 1'b1) begin n_errors++; $display("FAIL halt_deliver_valid: got %b want 1", if_valid); end
    n_checks++; if (if_instr !== 16'hBF00) begin n_errors++; $display("FAIL halt_deliver_instr: got %h want bf00", if_instr); end
    n_checks++; if (if_pc !== 16'h0010) begin n_errors++; $display("FAIL halt_deliver_pc: got %h want 0010", if_pc); end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL halt_once: got %b want 0", if_valid); end
    n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_errors++; $display("FAIL halt_hold: got halted %b req %b want 1 0", halted, imem_req); end
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL halt_exit: got %b want 0", halted); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin n_errors++; $display("FAIL halt_resume: got req %b addr %h want 1 0100", imem_req, imem_addr); end
    tick();
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== 16'h1100) begin n_errors++; $display("FAIL halt_resume_data: got %b %h %h want 1 0100 1100", if_valid, if_pc, if_instr); end
    halt_en = 1'b0;
  endtask

  task automatic test_stall_prefetch();
    int x0;
    logic [15:0] exp_addr;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0200; stall = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    x0 = xfer_cnt;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin n_errors++; $display("FAIL stall_start: got req %b addr %h want 1 0200", imem_req, imem_addr); end
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++; if (if_valid !== 1'b0 || if_instr !== 16'hBF00 || if_pc !== 16'h0000) begin n_errors++; $display("FAIL stall_hold_%0d: got %b %h %h want 0 bf00 0000", e, if_valid, if_instr, if_pc); end
      n_checks++; if (imem_req !== (e == 0 && DEPTH == 2)) begin n_errors++; $display("FAIL stall_req_%0d: got %b want %b", e, imem_req, (e == 0 && DEPTH == 2)); end
    end
    n_checks++; if (xfer_cnt - x0 !== DEPTH) begin n_errors++; $display("FAIL stall_xfers: got %0d want %0d", xfer_cnt - x0, DEPTH); end
    stall = 1'b0;
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0200 || if_instr !== 16'h1200) begin n_errors++; $display("FAIL stall_release: got %b %h %h want 1 0200 1200", if_valid, if_pc, if_instr); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_release_req: got %b want 0", imem_req); end
    tick();
    exp_addr = (DEPTH == 2) ? 16'h0204 : 16'h0202;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_errors++; $display("FAIL stall_refetch: got req %b addr %h want 1 %h", imem_req, imem_addr, exp_addr); end
  endtask

  task automatic test_wrap();
    logic        got_req;
    logic        saw_top;
    logic [15:0] first_addr;
    got_req = 1'b0; saw_top = 1'b0; first_addr = 16'hDEAD;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 16'hFFFE) begin n_errors++; $display("FAIL wrap_top_addr: got %h want fffe", imem_addr); end
    for (int e = 0; e < 6; e++) begin
      tick();
      if (imem_req && !got_req) begin got_req = 1'b1; first_addr = imem_addr; end
      if (if_valid && if_pc == 16'hFFFE && if_instr == 16'h0FFE) saw_top = 1'b1;
    end
    n_checks++; if (got_req !== 1'b1 || first_addr !== 16'h0000) begin n_errors++; $display("FAIL wrap_next_addr: got req %b addr %h want 1 0000", got_req, first_addr); end
    n_checks++; if (saw_top !== 1'b1) begin n_errors++; $display("FAIL wrap_deliver: got %b want 1", saw_top); end
  endtask

  task automatic test_ack_low();
    do_reset();
    imem_ack = 1'b0;
    tick();
    for (int e = 0; e < 4; e++) begin
      tick();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_errors++; $display("FAIL acklow_addr_%0d: got req %b addr %h want 1 0000", e, imem_req, imem_addr); end
      n_checks++; if (if_valid !== 1'b0 || if_instr !== 16'hBF00) begin n_errors++; $display("FAIL acklow_bubble_%0d: got %b %h want 0 bf00", e, if_valid, if_instr); end
    end
    imem_ack = 1'b1;
    tick();
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1000) begin n_errors++; $display("FAIL acklow_deliver: got %b %h %h want 1 0000 1000", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0300;
    tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 16'h0300) begin n_errors++; $display("FAIL rmid_addr: got %h want 0300", imem_addr); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin n_errors++; $display("FAIL rmid_async: got req %b addr %h want 0 0000", imem_req, imem_addr); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rmid_boot_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_errors++; $display("FAIL rmid_first_req: got req %b addr %h want 1 0000", imem_req, imem_addr); end
    tick();
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1000) begin n_errors++; $display("FAIL rmid_deliver: got %b %h %h want 1 0000 1000", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    xfer_cnt = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_halt();
    test_stall_prefetch();
    test_wrap();
    test_ack_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  16  byte address of the requested halfword.
REQ-006 SHALL have port imem_ack  input  1  memory completes the request this cycle.
REQ-007 SHALL have port imem_rdata  input  16  instruction data, valid when imem_ack=1.
REQ-008 SHALL have port stall  input  1  hazard hold of the IF/ID outputs.
REQ-009 SHALL have port redirect  input  1  branch taken or flush request.
REQ-010 SHALL have port redirect_pc  input  16  branch target address.
REQ-011 SHALL have port if_instr  output  16  registered instruction to the decoder.
REQ-012 SHALL have port if_pc  output  16  registered address of if_instr.
REQ-013 SHALL have port if_valid  output  1  if_instr is a real fetched instruction.
REQ-014 SHALL have port halted  output  1  high while the FSM is in HALT.

Function
REQ-015 SHALL hold fetch_pc, a FIFO of {pc, instr} of depth DEPTH, and FSM states BOOT, FETCH, WAIT_SPACE, HALT.
REQ-016 SHALL drive imem_req = (state==FETCH) && !redirect, and imem_addr = fetch_pc.
REQ-017 SHALL treat the memory as a stateless responder: a transfer occurs on an edge with imem_req && imem_ack; imem_addr is stable while imem_req=1 and no ack; dropping imem_req on redirect is a legal abort.
REQ-018 On transfer, SHALL push {fetch_pc, imem_rdata} into the FIFO and set fetch_pc = fetch_pc + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
REQ-019 FSM transitions SHALL be: BOOT -> FETCH after one cycle; FETCH -> HALT on transfer with imem_rdata == 16'hBF00; otherwise FETCH -> WAIT_SPACE on a transfer that fills the FIFO with no same-edge pop; WAIT_SPACE -> FETCH when the FIFO count < DEPTH; HALT is left only via redirect.
REQ-020 The FIFO SHALL never overflow; a push and a pop on the same edge SHALL leave the count unchanged.
REQ-021 On each edge with stall=0 and redirect=0, the IF/ID outputs SHALL load the FIFO head and pop it with if_valid=1, or load the bubble (if_instr=16'hBF00, if_valid=0, if_pc unchanged) if the FIFO is empty.
REQ-022 On an edge with stall=1 and redirect=0, the IF/ID outputs and the FIFO head SHALL hold; fetching continues into free FIFO slots.
REQ-023 Minimum latency SHALL be: data transferred at edge N appears on if_instr after edge N+1, when the FIFO was empty and stall=0.
REQ-024 On an edge with redirect=1, from any state and overriding stall, the block SHALL:
- clear the FIFO;
- discard any same-cycle imem_ack data;
- set fetch_pc = {redirect_pc[15:1], 1'b0};
- load the bubble;
- enter FETCH.
REQ-025 A halting 16'hBF00 SHALL still be delivered once with if_valid=1, in order.

Reset
REQ-026 While reset=1, SHALL asynchronously force:
- state=BOOT, fetch_pc=RESET_PC, FIFO empty;
- if_instr=16'hBF00, if_pc=RESET_PC, if_valid=0;
- halted=0, imem_req=0.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer; the first request after release SHALL be to RESET_PC, one cycle after release.

Configuration
REQ-028 With macro PREFETCH_BUF_EN defined, DEPTH SHALL be 2 (prefetch across one stall cycle); undefined, DEPTH SHALL be 1 and the block SHALL behave identically otherwise.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, RESET_PC=16'h0000, ack always 1 -> imem_addr 0,2,4,...; if_pc 0,2,4,... with if_valid=1 from the third cycle after release.
- Redirect with redirect_pc=16'h0041 while the FIFO is full -> bubble next cycle; next request addr 16'h0040; no stale instruction delivered.
- Fetch returns 16'hBF00 at 16'h0010 -> halted=1, imem_req=0; BF00 delivered with if_valid=1; redirect to 16'h0100 resumes fetch.
- stall=1 for 3 cycles with PREFETCH_BUF_EN -> outputs held; two further requests complete; then imem_req=0 until a pop.
- fetch_pc=16'hFFFE, transfer -> next imem_addr 16'h0000.
- imem_ack low for 4 cycles -> imem_addr stable; if_valid=0 with if_instr=16'hBF00 each cycle.
